muldiv_unit: RTL

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time and computes it over a fixed number of cycles using a shift-and-add / restoring-divide datapath with its own 33-bit adder. It reports completion with a one-cycle `done` pulse and holds the result. The hazard unit stalls the pipeline while `busy` is high.

---
 rtl/muldiv_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit for the execute stage. One operation is
// accepted at a time and computed over 32 shift-and-add (multiply) or
// restoring-divide iterations on unsigned magnitudes, followed by one
// sign-fix cycle. Completion is a one-cycle done pulse; the result is held
// until the next operation completes.
//
// Ports
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset
//   i_start   operation request, only looked at in IDLE
//   i_op      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_a       rs1 operand (multiplicand / dividend), captured on accept
//   i_b       rs2 operand (multiplier / divisor), captured on accept
//   i_flush   kills an in-flight operation, suppresses accept in IDLE
//   o_busy    high while computing (CALC and FIX)
//   o_done    one-cycle completion pulse
//   o_result  result, updated only at completion or on reset
// ---------------------------------------------------------------------------
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negate.
    function automatic logic [31:0] f_neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] f_neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_op;
    logic [31:0] r_a;        // |multiplicand|, or |dividend| shifted out MSB-first
    logic [31:0] r_b;        // |multiplier| shifted out LSB-first, or |divisor|
    logic [31:0] r_a_orig;   // original rs1, returned by REM/REMU on divide by zero
    logic [63:0] r_acc;      // product, or {remainder, quotient}
    logic [4:0]  r_cnt;
    logic        r_neg;      // product / quotient must be negated
    logic        r_rem_neg;  // remainder takes the dividend's sign
    logic        r_div0;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sa;
    logic        w_sb;
    logic [32:0] w_mul_sum;
    logic [32:0] w_mul_hi;
    logic [32:0] w_rem_sh;
    logic        w_div_ok;
    logic [31:0] w_div_diff;
    logic [63:0] w_acc_step;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_result;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_sa     = w_a_signed & i_a[31];
    assign w_sb     = w_b_signed & i_b[31];

    // Operand signedness for the incoming op.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (i_op)
            OP_MULH:        begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OP_MULHSU:      begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            OP_DIV, OP_REM: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
    end

    // One iteration of the datapath; the 33-bit sum/compare is the unit's own adder.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_a};
        w_mul_hi   = r_b[0] ? w_mul_sum : {1'b0, r_acc[63:32]};
        // Shifted partial remainder can reach 33 bits when the divisor is >= 2^31.
        w_rem_sh   = {r_acc[63:32], r_a[31]};
        w_div_ok   = (w_rem_sh >= {1'b0, r_b});
        // When the trial succeeds the difference is below the divisor, so 32 bits suffice.
        w_div_diff = w_rem_sh[31:0] - r_b;
        if (r_op[2]) begin
            w_acc_step = {(w_div_ok ? w_div_diff : w_rem_sh[31:0]), r_acc[30:0], w_div_ok};
        end else begin
            w_acc_step = {w_mul_hi, r_acc[31:1]};
        end
    end

    // Sign fix and result selection, including divide special cases.
    always_comb begin
        w_prod = r_neg ? f_neg64(r_acc) : r_acc;
        w_quo  = r_neg ? f_neg32(r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_rem_neg ? f_neg32(r_acc[63:32]) : r_acc[63:32];
        case (r_op)
            OP_MUL:                      w_fix_result = w_prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[63:32];
            OP_DIV, OP_DIVU: begin
                if (r_div0) begin
                    w_fix_result = 32'hFFFF_FFFF;
                end else if (r_ovf) begin
                    w_fix_result = 32'h8000_0000;
                end else begin
                    w_fix_result = w_quo;
                end
            end
            OP_REM, OP_REMU: begin
                if (r_div0) begin
                    w_fix_result = r_a_orig;
                end else if (r_ovf) begin
                    w_fix_result = 32'h0000_0000;
                end else begin
                    w_fix_result = w_rem;
                end
            end
            default:                     w_fix_result = 32'h0000_0000;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = w_accept ? S_CALC : S_IDLE;
            S_CALC: begin
                if (i_flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_state_next = S_FIX;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_FIX:  w_state_next = i_flush ? S_IDLE : S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_op      <= 3'b000;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_a_orig  <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_CALC) || (w_state_next == S_FIX);
            r_done  <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_op      <= i_op;
                r_a       <= w_sa ? f_neg32(i_a) : i_a;
                r_b       <= w_sb ? f_neg32(i_b) : i_b;
                r_a_orig  <= i_a;
                r_acc     <= 64'd0;
                r_cnt     <= 5'd0;
                r_neg     <= w_sa ^ w_sb;
                r_rem_neg <= w_sa;
                r_div0    <= (i_b == 32'd0);
                r_ovf     <= w_a_signed && w_b_signed && i_op[2] &&
                             (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + 5'd1;
                if (r_op[2]) begin
                    r_a <= {r_a[30:0], 1'b0};
                end else begin
                    r_b <= {1'b0, r_b[31:1]};
                end
            end
            if ((r_state == S_FIX) && !i_flush) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule
